scope_ui_ctrl: RTL

- Parametrised N-channel front-panel controller for the oscilloscope.
- Turns switches and four active-low push buttons into cursor positions, per-channel vertical offsets, per-channel shift (squish) factors, and enables for the VGA and sample path.
- Additions: internal tick divider, button synchroniser, press/auto-repeat FSM, saturating arithmetic, lock-step cursor pairs, default recall and a freeze mode.

---
 rtl/scope_ui_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/scope_ui_ctrl.sv
// Oscilloscope front-panel controller: switches and active-low buttons drive cursors,
// per-channel offsets/shifts and display enables, all paced by an internal divided tick.
module scope_ui_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int POS_W      = 11,
    parameter int SHIFT_W    = 4,
    parameter int SHIFT_MAX  = 11,
    parameter int TICK_DIV   = 20,
    parameter int HOLD_TICKS = 8,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int DEF_X1     = 32,
    parameter int DEF_X2     = 90,
    parameter int DEF_Y1     = 25,
    parameter int DEF_Y2     = 100,
    parameter int OFF_BASE   = 30,
    parameter int OFF_STEP   = 100,
    parameter int DEF_SHIFT  = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  mode,
    input  logic [1:0]                  sw_en,
    input  logic [1:0]                  sw_sel,
    input  logic [CH_W-1:0]             ch_sel,
    input  logic [3:0]                  butt,
    output logic [POS_W-1:0]            cursorX1,
    output logic [POS_W-1:0]            cursorX2,
    output logic [POS_W-1:0]            cursorY1,
    output logic [POS_W-1:0]            cursorY2,
    output logic                        cursor_x_en,
    output logic                        cursor_y_en,
    output logic [NUM_CH-1:0]           ch_en,
    output logic [NUM_CH*POS_W-1:0]     ch_offset,
    output logic [NUM_CH*SHIFT_W-1:0]   ch_shift,
    output logic                        tick
);

    localparam logic [1:0] MODE_CURSOR = 2'b00;
    localparam logic [1:0] MODE_WAVE   = 2'b01;
    localparam logic [1:0] MODE_RECALL = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    localparam int HOLD_W = $clog2(HOLD_TICKS) + 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [TICK_DIV-1:0] DIV_PRE   = TICK_DIV'((1 << TICK_DIV) - 2);
    localparam logic [POS_W-1:0]    X_LIM     = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]    Y_LIM     = POS_W'(Y_MAX);
    localparam logic [SHIFT_W-1:0]  SH_LIM    = SHIFT_W'(SHIFT_MAX);
    localparam logic [SHIFT_W-1:0]  SH_DEF    = SHIFT_W'(DEF_SHIFT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRE   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    function automatic logic [POS_W-1:0] inc_pos(input logic [POS_W-1:0] v, input logic [POS_W-1:0] lim);
        return (v >= lim) ? lim : v + POS_W'(1);
    endfunction

    function automatic logic [POS_W-1:0] dec_pos(input logic [POS_W-1:0] v);
        return (v == '0) ? '0 : v - POS_W'(1);
    endfunction

    function automatic logic [SHIFT_W-1:0] inc_sh(input logic [SHIFT_W-1:0] v);
        return (v >= SH_LIM) ? SH_LIM : v + SHIFT_W'(1);
    endfunction

    function automatic logic [SHIFT_W-1:0] dec_sh(input logic [SHIFT_W-1:0] v);
        return (v == '0) ? '0 : v - SHIFT_W'(1);
    endfunction

    function automatic logic [POS_W-1:0] off_default(input int idx);
        return POS_W'(OFF_BASE + idx * OFF_STEP);
    endfunction

    logic [TICK_DIV-1:0]        div_q;
    logic                       tick_q;
    logic [3:0]                 sync1_q, sync2_q;
    logic [3:0]                 pressed_s;
    logic                       any_s;
    logic [1:0]                 win_s;
    state_t                     state_q;
    logic [1:0]                 act_q;
    logic [HOLD_W-1:0]          hold_q;
    logic                       active_s, fire_s, rep_s;
    logic [POS_W-1:0]           x1_q, x2_q, y1_q, y2_q, x1_d, x2_d, y1_d, y2_d;
    logic                       xen_q, yen_q, xen_d, yen_d;
    logic [NUM_CH-1:0]          chen_q, chen_d;
    logic [NUM_CH*POS_W-1:0]    off_q, off_d;
    logic [NUM_CH*SHIFT_W-1:0]  sh_q, sh_d;
    logic [POS_W-1:0]           cur_off_s;
    logic [SHIFT_W-1:0]         cur_sh_s;

    // Tick divider; tick_q is asserted while the counter sits at its wrap value
    always_ff @(posedge clock) begin
        if (!reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_q + TICK_DIV'(1);
            tick_q <= (div_q == DIV_PRE);
        end
    end

    // Two-flop synchroniser; idle level of the buttons is high
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= butt;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = ~sync2_q;
    assign any_s     = |pressed_s;

    // Highest-index pressed button wins
    always_comb begin
        if (pressed_s[3]) begin
            win_s = 2'd3;
        end else if (pressed_s[2]) begin
            win_s = 2'd2;
        end else if (pressed_s[1]) begin
            win_s = 2'd1;
        end else begin
            win_s = 2'd0;
        end
    end

    assign active_s  = tick_q && (mode != MODE_FREEZE);
    assign fire_s    = active_s && (state_q == ST_FIRE);
    assign rep_s     = active_s && (state_q == ST_REPEAT) && pressed_s[act_q] && (win_s == act_q);
    assign cur_off_s = off_q[int'(ch_sel)*POS_W +: POS_W];
    assign cur_sh_s  = sh_q[int'(ch_sel)*SHIFT_W +: SHIFT_W];

    // Press / hold / auto-repeat sequencer, advanced only on ticks
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            act_q   <= 2'd0;
            hold_q  <= '0;
        end else if (tick_q) begin
            if (mode == MODE_FREEZE) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (any_s) begin
                            act_q   <= win_s;
                            state_q <= ST_FIRE;
                        end
                    end
                    ST_FIRE: begin
                        hold_q  <= '0;
                        state_q <= pressed_s[act_q] ? ST_HOLD : ST_IDLE;
                    end
                    ST_HOLD: begin
                        if (!pressed_s[act_q]) begin
                            state_q <= ST_IDLE;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                            if ((hold_q + HOLD_W'(1)) == HOLD_LAST) begin
                                state_q <= ST_REPEAT;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (any_s && (win_s != act_q)) begin
                            act_q   <= win_s;
                            state_q <= ST_FIRE;
                        end else if (!pressed_s[act_q]) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Next value of every user register; lock mode moves a pair only if both stay in range
    always_comb begin
        x1_d   = x1_q;
        x2_d   = x2_q;
        y1_d   = y1_q;
        y2_d   = y2_q;
        xen_d  = xen_q;
        yen_d  = yen_q;
        chen_d = chen_q;
        off_d  = off_q;
        sh_d   = sh_q;
        if (active_s && (mode == MODE_CURSOR)) begin
            xen_d = sw_en[0];
            yen_d = sw_en[1];
        end else if (active_s && (mode == MODE_WAVE)) begin
            chen_d[ch_sel] = sw_en[0];
        end else begin
            chen_d = chen_q;
        end
        if (fire_s || rep_s) begin
            case (mode)
                MODE_CURSOR: begin
                    case (sw_sel)
                        2'b01: begin
                            case (act_q)
                                2'd3:    x1_d = inc_pos(x1_q, X_LIM);
                                2'd2:    x1_d = dec_pos(x1_q);
                                2'd1:    x2_d = inc_pos(x2_q, X_LIM);
                                default: x2_d = dec_pos(x2_q);
                            endcase
                        end
                        2'b10: begin
                            case (act_q)
                                2'd3:    y1_d = inc_pos(y1_q, Y_LIM);
                                2'd2:    y1_d = dec_pos(y1_q);
                                2'd1:    y2_d = inc_pos(y2_q, Y_LIM);
                                default: y2_d = dec_pos(y2_q);
                            endcase
                        end
                        2'b11: begin
                            case (act_q)
                                2'd3: begin
                                    if ((y1_q < Y_LIM) && (y2_q < Y_LIM)) begin
                                        y1_d = y1_q + POS_W'(1);
                                        y2_d = y2_q + POS_W'(1);
                                    end else begin
                                        y1_d = y1_q;
                                    end
                                end
                                2'd2: begin
                                    if ((y1_q != '0) && (y2_q != '0)) begin
                                        y1_d = y1_q - POS_W'(1);
                                        y2_d = y2_q - POS_W'(1);
                                    end else begin
                                        y1_d = y1_q;
                                    end
                                end
                                2'd1: begin
                                    if ((x1_q < X_LIM) && (x2_q < X_LIM)) begin
                                        x1_d = x1_q + POS_W'(1);
                                        x2_d = x2_q + POS_W'(1);
                                    end else begin
                                        x1_d = x1_q;
                                    end
                                end
                                default: begin
                                    if ((x1_q != '0) && (x2_q != '0)) begin
                                        x1_d = x1_q - POS_W'(1);
                                        x2_d = x2_q - POS_W'(1);
                                    end else begin
                                        x1_d = x1_q;
                                    end
                                end
                            endcase
                        end
                        default: x1_d = x1_q;
                    endcase
                end
                MODE_WAVE: begin
                    case (act_q)
                        2'd3: begin
                            if (sw_sel[0]) begin
                                off_d[int'(ch_sel)*POS_W +: POS_W] = inc_pos(cur_off_s, Y_LIM);
                            end else begin
                                off_d = off_q;
                            end
                        end
                        2'd2: begin
                            if (sw_sel[0]) begin
                                off_d[int'(ch_sel)*POS_W +: POS_W] = dec_pos(cur_off_s);
                            end else begin
                                off_d = off_q;
                            end
                        end
                        2'd1: begin
                            if (sw_sel[1] && fire_s) begin
                                sh_d[int'(ch_sel)*SHIFT_W +: SHIFT_W] = inc_sh(cur_sh_s);
                            end else begin
                                sh_d = sh_q;
                            end
                        end
                        default: begin
                            if (sw_sel[1] && fire_s) begin
                                sh_d[int'(ch_sel)*SHIFT_W +: SHIFT_W] = dec_sh(cur_sh_s);
                            end else begin
                                sh_d = sh_q;
                            end
                        end
                    endcase
                end
                MODE_RECALL: begin
                    if (fire_s && (act_q == 2'd3)) begin
                        x1_d = POS_W'(DEF_X1);
                        x2_d = POS_W'(DEF_X2);
                        y1_d = POS_W'(DEF_Y1);
                        y2_d = POS_W'(DEF_Y2);
                    end else if (fire_s && (act_q == 2'd2)) begin
                        off_d[int'(ch_sel)*POS_W +: POS_W]    = off_default(int'(ch_sel));
                        sh_d[int'(ch_sel)*SHIFT_W +: SHIFT_W] = SH_DEF;
                    end else begin
                        x1_d = x1_q;
                    end
                end
                default: x1_d = x1_q;
            endcase
        end else begin
            x1_d = x1_q;
        end
    end

    // User-visible registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            x1_q   <= POS_W'(DEF_X1);
            x2_q   <= POS_W'(DEF_X2);
            y1_q   <= POS_W'(DEF_Y1);
            y2_q   <= POS_W'(DEF_Y2);
            xen_q  <= 1'b0;
            yen_q  <= 1'b0;
            chen_q <= '0;
            sh_q   <= {NUM_CH{SH_DEF}};
            for (int i = 0; i < NUM_CH; i++) begin
                off_q[i*POS_W +: POS_W] <= off_default(i);
            end
        end else begin
            x1_q   <= x1_d;
            x2_q   <= x2_d;
            y1_q   <= y1_d;
            y2_q   <= y2_d;
            xen_q  <= xen_d;
            yen_q  <= yen_d;
            chen_q <= chen_d;
            off_q  <= off_d;
            sh_q   <= sh_d;
        end
    end

    assign cursorX1    = x1_q;
    assign cursorX2    = x2_q;
    assign cursorY1    = y1_q;
    assign cursorY2    = y2_q;
    assign cursor_x_en = xen_q;
    assign cursor_y_en = yen_q;
    assign ch_en       = chen_q;
    assign ch_offset   = off_q;
    assign ch_shift    = sh_q;
    assign tick        = tick_q;

endmodule
